jcontrol_seq: RTL and testbench
===============================

JCONTROL_SEQ -- requirements
Module: jcontrol_seq

Interface
REQ-001 Reset is reset, synchronous, active-high; clock is clk.
REQ-002 clk  in  1  system clock; all state changes on posedge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 run  in  1  level; high = free-run instructions back to back.
REQ-005 step_req  in  1  one-cycle pulse; executes exactly one instruction while halted.
REQ-006 ir  in  8  instruction register contents; sampled from step 4 onward.
REQ-007 flags  in  4  {C,A,E,Z} from flags register.
REQ-008 step  out  6  one-hot step indicator, bit0 = step 1.
REQ-009 phase  out  2  quarter-step phase, 0..3.
REQ-010 halted  out  1  high while parked at step 1, phase 0, not advancing.
REQ-011 en  out  8  bus-driver enables {e_bus1,e_iar,e_ram,e_acc,e_reg3..0}, at most one e_reg set.
REQ-012 set  out  12  register set strobes {s_iar,s_mar,s_ir,s_acc,s_tmp,s_ram,s_flags,s_reg3..0,spare=0}.
REQ-013 alu_op  out  3  ALU operation; 000 (ADD) whenever no ALU op is defined.

Function
REQ-014 Each step lasts 4 clk cycles: phase 0 idle; phases 1-3 enables asserted; set strobes asserted only in phase 2.
REQ-015 After step 6 phase 3 the sequencer returns to step 1 phase 0; the full instruction takes exactly 24 cycles.
REQ-016 Fetch: step 1 e_bus1,e_iar,s_mar,s_acc; step 2 e_ram,s_ir; step 3 e_acc,s_iar.
REQ-017 ALU (ir[7]=1, op=ir[6:4], ra=ir[3:2], rb=ir[1:0]): s4 e_reg[rb],s_tmp; s5 e_reg[ra],s_acc,s_flags,alu_op=op; s6 e_acc,s_reg[rb], except op=111 (CMP) with no s6 strobes.
REQ-018 LD 0000: s4 e_reg[ra],s_mar; s5 e_ram,s_reg[rb]. ST 0001: s4 e_reg[ra],s_mar; s5 e_reg[rb],s_ram.
REQ-019 DATA 0010: s4 e_bus1,e_iar,s_mar,s_acc; s5 e_ram,s_reg[rb]; s6 e_acc,s_iar.
REQ-020 JMPR 0011: s4 e_reg[rb],s_iar. JMP 0100: s4 e_iar,s_mar; s5 e_ram,s_iar.
REQ-021 JMPIF 0101: s4 e_bus1,e_iar,s_mar,s_acc; s5 e_acc,s_iar; s6 e_ram,s_iar only if (ir[3:0] & flags) != 0.
REQ-022 CLF 0110: s4 e_bus1,s_flags. IO 0111 and all unlisted steps: no enables, no sets.
REQ-023 Unused steps still consume 4 cycles; no early termination.
REQ-024 Halted state: step=000001, phase=0, en=0, set=0; leaves halted on the cycle after run=1 or step_req=1.
REQ-025 run dropping mid-instruction: current instruction completes through step 6 phase 3, then halted=1.
REQ-026 step_req while not halted is ignored; step_req with run=1 is equivalent to run.
REQ-027 step_req while halted: one full 24-cycle instruction, then halted again regardless of further step_req pulses during it.

Reset
REQ-028 Reset: step=000001, phase=0, halted=1, en=0, set=0, alu_op=000; reset wins over run/step_req in the same cycle.
REQ-029 Reset asserted mid-instruction aborts it immediately; no set strobe occurs in the cycle following reset.

Structure
REQ-030 Shared package jcpu_pkg: opcode constants, ALU op codes, en/set bit index constants, phase constants.
REQ-031 Sub-module jphase_gen: phase counter plus one-hot step ring with run/halt gating; decode lives in jcontrol_seq.

Verification
REQ-032 Reset, run=1, ir=0x00 -> cycle 2 phase=2 with s_mar,s_acc; step 2 phase 2 s_ir; returns to step 1 after 24 cycles.
REQ-033 ir=0x86 (ADD r1,r2) -> s4 e_reg2+s_tmp; s5 e_reg1+s_acc+s_flags, alu_op=000; s6 s_reg2; ir=0xF6 -> no s6 strobes.
REQ-034 ir=0x52, flags=0010 -> step 6 phase 2 e_ram+s_iar; flags=0001 -> step 6 silent.
REQ-035 Halted, step_req pulse -> exactly 24 cycles active, halted=1 after; second pulse mid-instruction ignored.
REQ-036 run 1->0 at step 3 -> completes step 6, halts at step=000001, phase=0.
REQ-037 reset at step 5 phase 1 with ir=0x01 -> s_ram never asserted; outputs at reset values next cycle.

Source files
------------

// File: rtl/jcpu_pkg.sv
// Shared constants for the CPU control sequencer: opcodes, ALU codes,
// bus-enable / set-strobe bit positions and quarter-step phase values.
package jcpu_pkg;

    localparam logic [3:0] OP_LD    = 4'b0000;
    localparam logic [3:0] OP_ST    = 4'b0001;
    localparam logic [3:0] OP_DATA  = 4'b0010;
    localparam logic [3:0] OP_JMPR  = 4'b0011;
    localparam logic [3:0] OP_JMP   = 4'b0100;
    localparam logic [3:0] OP_JMPIF = 4'b0101;
    localparam logic [3:0] OP_CLF   = 4'b0110;
    localparam logic [3:0] OP_IO    = 4'b0111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHR = 3'b001;
    localparam logic [2:0] ALU_SHL = 3'b010;
    localparam logic [2:0] ALU_NOT = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    localparam int EN_BUS1 = 7;
    localparam int EN_IAR  = 6;
    localparam int EN_RAM  = 5;
    localparam int EN_ACC  = 4;
    localparam int EN_REG0 = 0;

    localparam int SET_IAR   = 11;
    localparam int SET_MAR   = 10;
    localparam int SET_IR    = 9;
    localparam int SET_ACC   = 8;
    localparam int SET_TMP   = 7;
    localparam int SET_RAM   = 6;
    localparam int SET_FLAGS = 5;
    localparam int SET_REG0  = 1;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_1    = 2'd1;
    localparam logic [1:0] PH_SET  = 2'd2;
    localparam logic [1:0] PH_3    = 2'd3;

    typedef enum logic {
        SEQ_HALT = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_t;

    function automatic logic [3:0] reg_sel(input logic [1:0] r);
        reg_sel = 4'b0001 << r;
    endfunction

endpackage

// File: rtl/jphase_gen.sv
// Quarter-step phase counter and one-hot six-step ring, parked at
// step 1 / phase 0 while halted.
import jcpu_pkg::*;

module jphase_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run,
    input  logic       i_step_req,
    output logic [5:0] o_step,
    output logic [1:0] o_phase,
    output logic       o_halted
);

    seq_state_t r_state, w_state_nxt;
    logic [1:0] r_phase, w_phase_nxt;
    logic [5:0] r_step,  w_step_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEQ_HALT;
            r_phase <= PH_IDLE;
            r_step  <= 6'b000001;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_step_nxt  = r_step;
        unique case (r_state)
            SEQ_HALT: begin
                // The parked cycle doubles as phase 0 of step 1.
                if (i_run || i_step_req) begin
                    w_state_nxt = SEQ_RUN;
                    w_phase_nxt = PH_1;
                end
            end
            SEQ_RUN: begin
                w_phase_nxt = r_phase + 2'd1;
                if (r_phase == PH_3) begin
                    w_step_nxt = {r_step[4:0], r_step[5]};
                    if (r_step[5] && !i_run)
                        w_state_nxt = SEQ_HALT;
                end
            end
            default: w_state_nxt = SEQ_HALT;
        endcase
    end

    assign o_step   = r_step;
    assign o_phase  = r_phase;
    assign o_halted = (r_state == SEQ_HALT);

endmodule

// File: rtl/jcontrol_seq.sv
// Control sequencer: fetch/execute step decode into bus enables, register
// set strobes and ALU operation, timed by jphase_gen.
import jcpu_pkg::*;

module jcontrol_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step_req,
    input  logic [7:0]  ir,
    input  logic [3:0]  flags,
    output logic [5:0]  step,
    output logic [1:0]  phase,
    output logic        halted,
    output logic [7:0]  en,
    output logic [11:0] set,
    output logic [2:0]  alu_op
);

    logic [5:0]  w_step;
    logic [1:0]  w_phase;
    logic        w_halted;
    logic [7:0]  w_en_s;
    logic [11:0] w_set_s;
    logic [2:0]  w_alu_s;
    logic [1:0]  w_ra, w_rb;

    jphase_gen u_phase (
        .clk        (clk),
        .reset      (reset),
        .i_run      (run),
        .i_step_req (step_req),
        .o_step     (w_step),
        .o_phase    (w_phase),
        .o_halted   (w_halted)
    );

    assign w_ra = ir[3:2];
    assign w_rb = ir[1:0];

    // Per-step controls before phase gating.
    always_comb begin
        w_en_s  = '0;
        w_set_s = '0;
        w_alu_s = ALU_ADD;
        if (w_step[0]) begin
            w_en_s[EN_BUS1]  = 1'b1;
            w_en_s[EN_IAR]   = 1'b1;
            w_set_s[SET_MAR] = 1'b1;
            w_set_s[SET_ACC] = 1'b1;
        end else if (w_step[1]) begin
            w_en_s[EN_RAM]  = 1'b1;
            w_set_s[SET_IR] = 1'b1;
        end else if (w_step[2]) begin
            w_en_s[EN_ACC]   = 1'b1;
            w_set_s[SET_IAR] = 1'b1;
        end else if (ir[7]) begin
            if (w_step[3]) begin
                w_en_s[EN_REG0 +: 4] = reg_sel(w_rb);
                w_set_s[SET_TMP]     = 1'b1;
            end else if (w_step[4]) begin
                w_en_s[EN_REG0 +: 4] = reg_sel(w_ra);
                w_set_s[SET_ACC]     = 1'b1;
                w_set_s[SET_FLAGS]   = 1'b1;
                w_alu_s              = ir[6:4];
            end else if (w_step[5] && ir[6:4] != ALU_CMP) begin
                w_en_s[EN_ACC]         = 1'b1;
                w_set_s[SET_REG0 +: 4] = reg_sel(w_rb);
            end
        end else begin
            unique case (ir[7:4])
                OP_LD: begin
                    if (w_step[3]) begin
                        w_en_s[EN_REG0 +: 4] = reg_sel(w_ra);
                        w_set_s[SET_MAR]     = 1'b1;
                    end else if (w_step[4]) begin
                        w_en_s[EN_RAM]         = 1'b1;
                        w_set_s[SET_REG0 +: 4] = reg_sel(w_rb);
                    end
                end
                OP_ST: begin
                    if (w_step[3]) begin
                        w_en_s[EN_REG0 +: 4] = reg_sel(w_ra);
                        w_set_s[SET_MAR]     = 1'b1;
                    end else if (w_step[4]) begin
                        w_en_s[EN_REG0 +: 4] = reg_sel(w_rb);
                        w_set_s[SET_RAM]     = 1'b1;
                    end
                end
                OP_DATA: begin
                    if (w_step[3]) begin
                        w_en_s[EN_BUS1]  = 1'b1;
                        w_en_s[EN_IAR]   = 1'b1;
                        w_set_s[SET_MAR] = 1'b1;
                        w_set_s[SET_ACC] = 1'b1;
                    end else if (w_step[4]) begin
                        w_en_s[EN_RAM]         = 1'b1;
                        w_set_s[SET_REG0 +: 4] = reg_sel(w_rb);
                    end else if (w_step[5]) begin
                        w_en_s[EN_ACC]   = 1'b1;
                        w_set_s[SET_IAR] = 1'b1;
                    end
                end
                OP_JMPR: begin
                    if (w_step[3]) begin
                        w_en_s[EN_REG0 +: 4] = reg_sel(w_rb);
                        w_set_s[SET_IAR]     = 1'b1;
                    end
                end
                OP_JMP: begin
                    if (w_step[3]) begin
                        w_en_s[EN_IAR]   = 1'b1;
                        w_set_s[SET_MAR] = 1'b1;
                    end else if (w_step[4]) begin
                        w_en_s[EN_RAM]   = 1'b1;
                        w_set_s[SET_IAR] = 1'b1;
                    end
                end
                OP_JMPIF: begin
                    // Step 5 loads the fall-through address; step 6 overrides it when taken.
                    if (w_step[3]) begin
                        w_en_s[EN_BUS1]  = 1'b1;
                        w_en_s[EN_IAR]   = 1'b1;
                        w_set_s[SET_MAR] = 1'b1;
                        w_set_s[SET_ACC] = 1'b1;
                    end else if (w_step[4]) begin
                        w_en_s[EN_ACC]   = 1'b1;
                        w_set_s[SET_IAR] = 1'b1;
                    end else if (w_step[5] && (ir[3:0] & flags) != 4'b0000) begin
                        w_en_s[EN_RAM]   = 1'b1;
                        w_set_s[SET_IAR] = 1'b1;
                    end
                end
                OP_CLF: begin
                    if (w_step[3]) begin
                        w_en_s[EN_BUS1]    = 1'b1;
                        w_set_s[SET_FLAGS] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign step   = w_step;
    assign phase  = w_phase;
    assign halted = w_halted;
    assign en     = (w_phase != PH_IDLE) ? w_en_s  : 8'h00;
    assign set    = (w_phase == PH_SET)  ? w_set_s : 12'h000;
    assign alu_op = (w_phase != PH_IDLE) ? w_alu_s : ALU_ADD;

endmodule

// File: tb/tb_jcontrol_seq.sv
// Directed bench for jcontrol_seq: decode vector table plus hand-written
// halt/step/reset sequences.
module tb_jcontrol_seq;

    logic        clk = 1'b0;
    logic        reset, run, step_req;
    logic [7:0]  ir;
    logic [3:0]  flags;
    logic [5:0]  step;
    logic [1:0]  phase;
    logic        halted;
    logic [7:0]  en;
    logic [11:0] set;
    logic [2:0]  alu_op;

    int n_cmp = 0;
    int n_bad = 0;

    jcontrol_seq dut (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req),
        .ir(ir), .flags(flags), .step(step), .phase(phase),
        .halted(halted), .en(en), .set(set), .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ir;
        logic [3:0]  fl;
        int          stp;
        logic [1:0]  ph;
        logic [7:0]  en;
        logic [11:0] st;
        logic [2:0]  alu;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] i, input logic [3:0] f, input int s, input logic [1:0] p,
                       input logic [7:0] e, input logic [11:0] st, input logic [2:0] a);
        vec_t v;
        v.ir = i; v.fl = f; v.stp = s; v.ph = p; v.en = e; v.st = st; v.alu = a;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; step_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_at(input int s, input logic [1:0] p, output bit ok);
        logic [5:0] target;
        target = 6'b000001 << (s - 1);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (step == target && phase == p) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int n;
        bit saw_s6, saw_ram;

        reset = 1'b1; run = 1'b0; step_req = 1'b0; ir = 8'h00; flags = 4'h0;

        // ir, flags, step, phase, en, set, alu
        add(8'h00, 4'h0, 1, 2'd2, 8'hC0, 12'h500, 3'd0);
        add(8'h00, 4'h0, 1, 2'd1, 8'hC0, 12'h000, 3'd0);
        add(8'h00, 4'h0, 1, 2'd3, 8'hC0, 12'h000, 3'd0);
        add(8'h00, 4'h0, 2, 2'd0, 8'h00, 12'h000, 3'd0);
        add(8'h00, 4'h0, 2, 2'd2, 8'h20, 12'h200, 3'd0);
        add(8'h00, 4'h0, 3, 2'd2, 8'h10, 12'h800, 3'd0);
        add(8'h86, 4'h0, 1, 2'd2, 8'hC0, 12'h500, 3'd0);
        add(8'h86, 4'h0, 4, 2'd2, 8'h04, 12'h080, 3'd0);
        add(8'h86, 4'h0, 5, 2'd2, 8'h02, 12'h120, 3'd0);
        add(8'h86, 4'h0, 6, 2'd2, 8'h10, 12'h008, 3'd0);
        add(8'hF6, 4'h0, 5, 2'd2, 8'h02, 12'h120, 3'd7);
        add(8'hF6, 4'h0, 6, 2'd2, 8'h00, 12'h000, 3'd0);
        add(8'hA7, 4'h0, 5, 2'd1, 8'h02, 12'h000, 3'd2);
        add(8'hA7, 4'h0, 5, 2'd0, 8'h00, 12'h000, 3'd0);
        add(8'hA7, 4'h0, 6, 2'd2, 8'h10, 12'h010, 3'd0);
        add(8'h0B, 4'h0, 4, 2'd2, 8'h04, 12'h400, 3'd0);
        add(8'h0B, 4'h0, 5, 2'd2, 8'h20, 12'h010, 3'd0);
        add(8'h0B, 4'h0, 6, 2'd2, 8'h00, 12'h000, 3'd0);
        add(8'h1E, 4'h0, 4, 2'd2, 8'h08, 12'h400, 3'd0);
        add(8'h1E, 4'h0, 5, 2'd2, 8'h04, 12'h040, 3'd0);
        add(8'h21, 4'h0, 4, 2'd2, 8'hC0, 12'h500, 3'd0);
        add(8'h21, 4'h0, 5, 2'd2, 8'h20, 12'h004, 3'd0);
        add(8'h21, 4'h0, 6, 2'd2, 8'h10, 12'h800, 3'd0);
        add(8'h32, 4'h0, 4, 2'd2, 8'h04, 12'h800, 3'd0);
        add(8'h32, 4'h0, 5, 2'd2, 8'h00, 12'h000, 3'd0);
        add(8'h40, 4'h0, 4, 2'd2, 8'h40, 12'h400, 3'd0);
        add(8'h40, 4'h0, 5, 2'd2, 8'h20, 12'h800, 3'd0);
        add(8'h52, 4'h2, 4, 2'd2, 8'hC0, 12'h500, 3'd0);
        add(8'h52, 4'h2, 5, 2'd2, 8'h10, 12'h800, 3'd0);
        add(8'h52, 4'h2, 6, 2'd2, 8'h20, 12'h800, 3'd0);
        add(8'h52, 4'h1, 6, 2'd2, 8'h00, 12'h000, 3'd0);
        add(8'h52, 4'h1, 6, 2'd1, 8'h00, 12'h000, 3'd0);
        add(8'h60, 4'h0, 4, 2'd2, 8'h80, 12'h020, 3'd0);
        add(8'h70, 4'h0, 4, 2'd2, 8'h00, 12'h000, 3'd0);
        add(8'h70, 4'h0, 5, 2'd2, 8'h00, 12'h000, 3'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            ir = vecs[i].ir; flags = vecs[i].fl; run = 1'b1;
            wait_at(vecs[i].stp, vecs[i].ph, ok);
            if (!ok) begin
                n_cmp++; n_bad++;
                $display("FAIL vec%0d_timeout: step/phase not reached, required step %0d phase %0d",
                         i, vecs[i].stp, vecs[i].ph);
            end else begin
                check($sformatf("vec%0d_ir%02h_s%0d_p%0d {en,set,alu}", i, vecs[i].ir, vecs[i].stp, vecs[i].ph),
                      {9'd0, en, set, alu_op}, {9'd0, vecs[i].en, vecs[i].st, vecs[i].alu});
            end
        end

        // Reset state, reset winning over run, fetch timing and 24-cycle period.
        reset = 1'b1; run = 1'b1; step_req = 1'b1; ir = 8'h00; flags = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state {step,phase,halted,en,set,alu}", {step, phase, halted, en, set, alu_op},
              {6'b000001, 2'd0, 1'b1, 8'h00, 12'h000, 3'd0});
        reset = 1'b0; step_req = 1'b0;
        @(negedge clk);
        check("fetch_cycle1_phase", {30'd0, phase}, 32'd1);
        @(negedge clk);
        check("fetch_cycle2 {phase,set}", {phase, set}, {2'd2, 12'h500});
        n = 0;
        for (int k = 3; k < 40; k++) begin
            @(negedge clk);
            if (step == 6'b000001 && phase == 2'd0) begin
                n = k;
                break;
            end
        end
        check("instr_period_cycles", n, 24);
        check("freerun_not_halted", {31'd0, halted}, 32'd0);

        // Single step from halt; a second pulse mid-instruction is ignored.
        do_reset();
        ir = 8'h86;
        step_req = 1'b1;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            step_req = (k == 10);
            if (halted) begin
                n = k;
                break;
            end
        end
        step_req = 1'b0;
        check("step_req_instr_cycles", n, 24);
        repeat (4) @(negedge clk);
        check("step_req_parked {step,phase,halted,en,set}", {step, phase, halted, en, set},
              {6'b000001, 2'd0, 1'b1, 8'h00, 12'h000});

        // run dropped during step 3: instruction completes, then parks.
        do_reset();
        ir = 8'h21; run = 1'b1;
        wait_at(3, 2'd1, ok);
        check("run_drop_reach_s3", {31'd0, ok}, 32'd1);
        run = 1'b0;
        saw_s6 = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (step == 6'b100000 && phase == 2'd3) saw_s6 = 1'b1;
            if (halted) begin
                n = k;
                break;
            end
        end
        check("run_drop_completed_s6", {31'd0, saw_s6}, 32'd1);
        check("run_drop_cycles_to_halt", n, 15);
        check("run_drop_parked {step,phase,halted}", {step, phase, halted}, {6'b000001, 2'd0, 1'b1});

        // Reset during ST step 5 phase 1: no RAM write ever happens.
        do_reset();
        ir = 8'h01; run = 1'b1;
        saw_ram = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (set[6]) saw_ram = 1'b1;
            if (step == 6'b010000 && phase == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach_s5p1", {31'd0, ok}, 32'd1);
        reset = 1'b1; run = 1'b0;
        @(negedge clk);
        if (set[6]) saw_ram = 1'b1;
        check("abort_reset_values {step,phase,halted,en,set,alu}", {step, phase, halted, en, set, alu_op},
              {6'b000001, 2'd0, 1'b1, 8'h00, 12'h000, 3'd0});
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (set[6]) saw_ram = 1'b1;
        end
        check("abort_no_s_ram", {31'd0, saw_ram}, 32'd0);
        check("abort_stays_halted", {31'd0, halted}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
